// File: rtl/req_encoder_rtl.sv
// -----------------------------------------------------------------------------
// req_encoder_rtl
//
// Sequential N-to-log2(N) request encoder. Request pulses are captured into a
// sticky pending vector. Pending requests are then handed out one encoded index
// at a time over a valid/ready handshake. Each bit is cleared as it is granted,
// so bursts of one-hot or multi-hot events are serialised instead of lost.
//
// Parameters:
//   N  number of request lines (power of 2, >= 2)
//   W  encoded index width, must equal log2(N)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       [N-1:0] request pulses (bit i requests index i)
//   clr       synchronous clear of pending requests and the output stage
//   y         [W-1:0] encoded index of the current grant
//   valid     y holds a grant awaiting acceptance
//   ready     consumer accepts y when valid && ready at a rising edge
//   pending   [N-1:0] registered requests not yet granted
//   overflow  one-cycle pulse: a request hit an already-pending bit
//
// Configuration:
//   REQ_ENCODER_ROUND_ROBIN_EN  when defined, selection is round-robin. It
//   starts from the index after the last grant and wraps. When undefined, the
//   lowest set index wins and no pointer register exists.
// -----------------------------------------------------------------------------
module req_encoder_rtl #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  // Convert a one-hot (or all-zero) vector into its binary index.
  function automatic logic [W-1:0] onehot_to_index(input logic [N-1:0] oh);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
    return idx;
  endfunction

  logic         load;         // output stage can take a new grant this edge
  logic         grant;        // a pending bit is handed out this edge
  logic [W-1:0] start;        // index the priority search begins at
  logic [N-1:0] rotated;      // pending rotated so that 'start' sits at bit 0
  logic [N-1:0] lowest;       // lowest set bit of 'rotated', isolated
  logic [W-1:0] sel_idx;      // absolute index chosen for the grant
  logic [N-1:0] grant_clear;  // pending bit retired by this grant
  logic [N-1:0] pending_next;
  logic         overflow_next;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] last_grant;

  // W == log2(N), so the W-bit sums wrap modulo N.
  assign start = last_grant + W'(1);
`else
  assign start = '0;
`endif

  // NOTE: every signal written in always_comb gets a default value first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < N; i++) begin
      rotated[i] = pending[start + W'(i)];
    end
  end

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  assign lowest  = rotated & (~rotated + N'(1));
  assign sel_idx = start + onehot_to_index(lowest);

  assign load  = !valid || ready;
  assign grant = load && (pending != '0);

  assign grant_clear = grant ? (N'(1) << sel_idx) : '0;

  // A request always sets its bit, even on the edge that grants it.
  assign pending_next  = (pending & ~grant_clear) | req;
  assign overflow_next = |(req & pending & ~grant_clear);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      y          <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      last_grant <= '0;
`endif
    end else if (clr) begin
      // clr has priority over req and ready; requests seen this edge are dropped.
      pending    <= '0;
      y          <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      last_grant <= '0;
`endif
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      if (load) begin
        if (grant) begin
          y     <= sel_idx;
          valid <= 1'b1;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
          last_grant <= sel_idx;
`endif
        end else begin
          // Nothing to hand out: drop valid and keep the last index on y.
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_encoder_rtl.sv
// -----------------------------------------------------------------------------
// tb_req_encoder_rtl
//
// Self-checking bench for req_encoder_rtl (N=4, W=2). A behavioural model
// follows the encoder's rules: sticky pending set, grant on a free output
// stage, set-wins-over-clear, overflow on duplicates, clr and async reset.
// Directed scenarios come first. A randomized run follows, with rare mid-cycle
// resets and clears. Inputs change 1 time unit after the rising edge. Outputs
// are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_req_encoder_rtl;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         clr = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] y;
  logic         valid;
  logic [N-1:0] pending;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [N-1:0] m_pending;
  logic [W-1:0] m_y;
  logic         m_valid;
  logic         m_ovf;
  int           m_last;

  req_encoder_rtl #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr      (clr),
    .y        (y),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index the encoder should grant from pending vector p, or -1 if none.
  function automatic int pick(input logic [N-1:0] p, input int last);
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (p[idx]) return idx;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (p[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_pending = '0;
    m_y       = '0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
    m_last    = 0;
  endtask

  // Advance the model by one rising edge, using the current inputs.
  task automatic model_edge();
    int           s;
    logic [N-1:0] gc;
    if (clr) begin
      model_reset();
      return;
    end
    gc = '0;
    if (!m_valid || ready) begin
      s = pick(m_pending, m_last);
      if (s >= 0) begin
        m_y     = s[W-1:0];
        m_valid = 1'b1;
        m_last  = s;
        gc[s]   = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && m_pending[i] && !gc[i]) m_ovf = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      m_pending[i] = (m_pending[i] && !gc[i]) || req[i];
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".y"},        32'(y),        32'(m_y));
    check({ctx, ".valid"},    32'(valid),    32'(m_valid));
    check({ctx, ".pending"},  32'(pending),  32'(m_pending));
    check({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ctx);
  endtask

  // Mid-cycle asynchronous reset. Outputs must clear before any clock edge.
  task automatic async_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef REQ_ENCODER_ROUND_ROBIN_EN
    // Single request: pending at k, grant at k+1, idle at k+2.
    ready = 1'b1;
    req = 4'b0100; tick("single.k");
    check("single.k.pending", 32'(pending), 32'h4);
    check("single.k.valid",   32'(valid),   32'h0);
    req = 4'b0000; tick("single.k1");
    check("single.k1.y",      32'(y),       32'h2);
    check("single.k1.valid",  32'(valid),   32'h1);
    tick("single.k2");
    check("single.k2.valid",  32'(valid),   32'h0);
    check("single.k2.pending", 32'(pending), 32'h0);

    // Multi-hot burst: fixed priority gives 0, 1, 3.
    req = 4'b1011; tick("burst.cap");
    req = 4'b0000; tick("burst.g0");
    check("burst.y0", 32'(y), 32'h0);
    tick("burst.g1");
    check("burst.y1", 32'(y), 32'h1);
    tick("burst.g3");
    check("burst.y3", 32'(y), 32'h3);
    check("burst.valid3", 32'(valid), 32'h1);
    tick("burst.idle");
    check("burst.idle.valid", 32'(valid), 32'h0);

    // Backpressure: y=1 is held for five cycles, then y=2 follows.
    ready = 1'b0;
    req = 4'b0110; tick("bp.cap");
    req = 4'b0000; tick("bp.g1");
    for (int i = 0; i < 5; i++) begin
      tick("bp.hold");
      check("bp.hold.y",       32'(y),       32'h1);
      check("bp.hold.valid",   32'(valid),   32'h1);
      check("bp.hold.pending", 32'(pending), 32'h4);
    end
    ready = 1'b1; tick("bp.g2");
    check("bp.g2.y", 32'(y), 32'h2);
    tick("bp.idle");

    // Overflow: a duplicate on pending[0] while the output is stalled.
    ready = 1'b0;
    req = 4'b0011; tick("ovf.cap");
    req = 4'b0000; tick("ovf.g0");
    req = 4'b0001; tick("ovf.set0");
    check("ovf.first", 32'(overflow), 32'h0);
    tick("ovf.dup");
    check("ovf.pulse", 32'(overflow), 32'h1);
    req = 4'b0000; tick("ovf.after");
    check("ovf.one_cycle", 32'(overflow), 32'h0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) tick("ovf.drain");

    // Set wins over clear: req[1] arrives on the edge that grants index 1.
    ready = 1'b0;
    req = 4'b0010; tick("swc.cap");
    ready = 1'b1; tick("swc.grant");
    check("swc.y",        32'(y),        32'h1);
    check("swc.pending",  32'(pending),  32'h2);
    check("swc.overflow", 32'(overflow), 32'h0);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick("swc.drain");

    // clr beats req and ready on the same edge.
    req = 4'b0101; tick("clr.pre");
    clr = 1'b1; req = 4'b1111; ready = 1'b1; tick("clr.edge");
    check("clr.pending", 32'(pending), 32'h0);
    check("clr.valid",   32'(valid),   32'h0);
    check("clr.y",       32'(y),       32'h0);
    clr = 1'b0; req = 4'b0000; tick("clr.next");
    check("clr.no_grant", 32'(valid), 32'h0);
`else
    // Round-robin: all requests held high give y = 1, 2, 3, 0, 1.
    begin
      logic [31:0] rr_exp [5];
      rr_exp = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h1};
      ready = 1'b1;
      req = 4'b1111; tick("rr.cap");
      for (int i = 0; i < 5; i++) begin
        tick("rr.seq");
        check("rr.y",     32'(y),     rr_exp[i]);
        check("rr.valid", 32'(valid), 32'h1);
      end
      req = 4'b0000;
      for (int i = 0; i < 5; i++) tick("rr.drain");
    end
`endif

    // Async reset with pending=1010 and valid=1.
    ready = 1'b0;
    req = 4'b1011; tick("rst.cap");
    req = 4'b0000; tick("rst.g");
    async_reset("rst.async");
    check("rst.y",        32'(y),        32'h0);
    check("rst.valid",    32'(valid),    32'h0);
    check("rst.pending",  32'(pending),  32'h0);
    check("rst.overflow", 32'(overflow), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 50) == 0);
      tick("rand");
      if ($urandom_range(0, 150) == 0) async_reset("rand.rst");
    end
    clr = 1'b0;
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
